// File: rtl/decode_pkg.sv
// decode_pkg: class encodings, opcodes and SYSTEM encodings for the decode queue.
// Shared by instruction_classifier and decode_queue.
package decode_pkg;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_ALUIMM  = 4'd7,
    CLS_ALU     = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_MULDIV  = 4'd11,
    CLS_INVALID = 4'd15
  } cls_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] SYS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] SYS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] SYS_MRET   = 32'h3020_0073;

  typedef struct packed {
    cls_e       cls;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    dec_t        dec;
  } entry_t;

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: enqueue handshake/payload and dequeue handshake/decoded head.
// slave = queue side, master = producer/consumer side.
interface decode_queue_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_pc;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [4:0]  out_rdIndex;
  logic [4:0]  out_rs1Index;
  logic [4:0]  out_rs2Index;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [3:0]  out_class;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instruction, in_pc, out_ready,
    output in_ready, out_valid, out_instruction, out_pc,
    output out_rdIndex, out_rs1Index, out_rs2Index,
    output out_funct3, out_funct7, out_class, out_illegal
  );

  modport master (
    output in_valid, in_instruction, in_pc, out_ready,
    input  in_ready, out_valid, out_instruction, out_pc,
    input  out_rdIndex, out_rs1Index, out_rs2Index,
    input  out_funct3, out_funct7, out_class, out_illegal
  );

endinterface

// File: rtl/instruction_classifier.sv
// instruction_classifier: combinational RV32I(+M) class/legality/field decode.
// In: i_instruction. Out: o_class, o_illegal, o_rd/o_rs1/o_rs2, o_funct3, o_funct7.
module instruction_classifier
  import decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] i_instruction,
  output cls_e        o_class,
  output logic        o_illegal,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_jalr_ok;
  logic       w_br_ok;
  logic       w_ld_ok;
  logic       w_st_ok;
  logic       w_sh_ok;
  logic       w_imm_ok;
  logic       w_alu_ok;
  logic       w_mul;
  logic       w_fence_ok;
  logic       w_sys_ok;

  assign w_op = i_instruction[6:0];
  assign w_f3 = i_instruction[14:12];
  assign w_f7 = i_instruction[31:25];

  assign o_rd     = i_instruction[11:7];
  assign o_rs1    = i_instruction[19:15];
  assign o_rs2    = i_instruction[24:20];
  assign o_funct3 = w_f3;
  assign o_funct7 = w_f7;

  assign w_jalr_ok  = (w_f3 == 3'b000);
  assign w_br_ok    = (w_f3 != 3'b010) && (w_f3 != 3'b011);
  assign w_ld_ok    = (w_f3 != 3'b011) && (w_f3 != 3'b110) &&
                      (w_f3 != 3'b111);
  assign w_st_ok    = !w_f3[2] && (w_f3[1:0] != 2'b11);
  assign w_sh_ok    = (w_f7 == F7_BASE) ||
                      ((w_f3 == 3'b101) && (w_f7 == F7_ALT));
  // funct3 001/101 are the shift-immediates; the rest ignore funct7
  assign w_imm_ok   = (w_f3[1:0] == 2'b01) ? w_sh_ok : 1'b1;
  assign w_alu_ok   = (w_f7 == F7_BASE) ||
                      ((w_f7 == F7_ALT) &&
                       ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
  assign w_mul      = ENABLE_M && (w_f7 == F7_MULDIV);
  assign w_fence_ok = (w_f3 == 3'b000);
  assign w_sys_ok   = ((w_f3 != 3'b000) && (w_f3 != 3'b100)) ||
                      (i_instruction == SYS_ECALL) ||
                      (i_instruction == SYS_EBREAK) ||
                      (i_instruction == SYS_MRET);

  // Every listed opcode ends in 2'b11, so compressed encodings
  // fall through to the default.
  always_comb begin
    o_class = CLS_INVALID;
    unique case (1'b1)
      (w_op == OP_LUI):    o_class = CLS_LUI;
      (w_op == OP_AUIPC):  o_class = CLS_AUIPC;
      (w_op == OP_JAL):    o_class = CLS_JAL;
      (w_op == OP_JALR):
        o_class = w_jalr_ok ? CLS_JALR : CLS_INVALID;
      (w_op == OP_BRANCH):
        o_class = w_br_ok ? CLS_BRANCH : CLS_INVALID;
      (w_op == OP_LOAD):
        o_class = w_ld_ok ? CLS_LOAD : CLS_INVALID;
      (w_op == OP_STORE):
        o_class = w_st_ok ? CLS_STORE : CLS_INVALID;
      (w_op == OP_IMM):
        o_class = w_imm_ok ? CLS_ALUIMM : CLS_INVALID;
      (w_op == OP_ALU):
        o_class = w_alu_ok ? CLS_ALU :
                  (w_mul ? CLS_MULDIV : CLS_INVALID);
      (w_op == OP_FENCE):
        o_class = w_fence_ok ? CLS_FENCE : CLS_INVALID;
      (w_op == OP_SYSTEM):
        o_class = w_sys_ok ? CLS_SYSTEM : CLS_INVALID;
      default: o_class = CLS_INVALID;
    endcase
  end

  assign o_illegal = (o_class == CLS_INVALID);

endmodule

// File: rtl/decode_queue.sv
// decode_queue: FIFO of pre-decoded instructions (decode at enqueue).
// Ports: clk, rst_n, flush, q (decode_queue_if.slave), count (occupancy).
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ENABLE_M = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  decode_queue_if.slave            q,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  entry_t        r_mem [DEPTH];

  cls_e          w_cls;
  logic          w_ill;
  logic [4:0]    w_rd;
  logic [4:0]    w_rs1;
  logic [4:0]    w_rs2;
  logic [2:0]    w_f3;
  logic [6:0]    w_f7;
  entry_t        w_entry;
  entry_t        w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;

  instruction_classifier #(
    .ENABLE_M (ENABLE_M != 0)
  ) u_cls (
    .i_instruction (q.in_instruction),
    .o_class       (w_cls),
    .o_illegal     (w_ill),
    .o_rd          (w_rd),
    .o_rs1         (w_rs1),
    .o_rs2         (w_rs2),
    .o_funct3      (w_f3),
    .o_funct7      (w_f7)
  );

  assign w_entry.instr       = q.in_instruction;
  assign w_entry.pc          = q.in_pc;
  assign w_entry.dec.cls     = w_cls;
  assign w_entry.dec.illegal = w_ill;
  assign w_entry.dec.rd      = w_rd;
  assign w_entry.dec.rs1     = w_rs1;
  assign w_entry.dec.rs2     = w_rs2;
  assign w_entry.dec.funct3  = w_f3;
  assign w_entry.dec.funct7  = w_f7;

  // in_ready looks only at registered occupancy: no pop bypass
  assign q.in_ready = (r_count < FULL);
  assign w_valid    = (r_count != '0);
  assign q.out_valid = w_valid;
  assign count      = r_count;

  assign w_push = q.in_valid && q.in_ready;
  assign w_pop  = w_valid && q.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= w_entry;
  end

  assign w_head = r_mem[r_rptr];

  assign q.out_instruction = w_valid ? w_head.instr : '0;
  assign q.out_pc          = w_valid ? w_head.pc : '0;
  assign q.out_rdIndex     = w_valid ? w_head.dec.rd : '0;
  assign q.out_rs1Index    = w_valid ? w_head.dec.rs1 : '0;
  assign q.out_rs2Index    = w_valid ? w_head.dec.rs2 : '0;
  assign q.out_funct3      = w_valid ? w_head.dec.funct3 : '0;
  assign q.out_funct7      = w_valid ? w_head.dec.funct7 : '0;
  assign q.out_class       = w_valid ? w_head.dec.cls : CLS_INVALID;
  assign q.out_illegal     = w_valid && w_head.dec.illegal;

endmodule
